cpu_single_cycle: RTL and testbench

//   Single-cycle 32-bit MIPS subset processor: one instruction fetched, decoded, executed and retired per clock.

---
 rtl/cpu_single_cycle.sv | 167 ++++++++++++++++
 tb/tb_cpu_single_cycle.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_single_cycle.sv
// Single-cycle MIPS subset core: fetch, decode, execute and retire one instruction per clock.
// Instruction and data memories are plain word arrays preloaded through hierarchy (b2v_im / b2v_DM).
`timescale 1ns/1ps

module cpu_mem #(
    parameter int WORDS = 256
) (
    input  logic        clk,
    input  logic        we,
    input  logic [29:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);
    localparam int AW = $clog2(WORDS);

    logic [31:0] memory [0:WORDS-1];
    logic        in_range;

    assign in_range = (addr < 30'(WORDS));

    always_ff @(posedge clk) begin
        if (we && in_range) begin
            memory[addr[AW-1:0]] <= wdata;
        end
    end

    // Out-of-range reads return zero, which decodes as a nop when fetched.
    always_comb begin
        rdata = '0;
        if (in_range) begin
            rdata = memory[addr[AW-1:0]];
        end
    end
endmodule

module cpu_single_cycle #(
    parameter int IM_WORDS = 256,
    parameter int DM_WORDS = 256
) (
    input  logic          clk,
    input  logic          rst,
    output logic          Overflow,
    output logic [31:26]  OPCODE,
    output logic [31:0]   PC
);
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    logic [31:0] pc, pc_plus4, next_pc, instr;
    logic [31:0] sext_imm, branch_target, jump_target;
    logic [31:0] rs_val, rt_val, sum, diff, imm_sum, mem_rdata, wr_data;
    logic [31:0] regs [0:31];
    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, wr_addr;
    logic        reg_write, mem_write, ovf;
    logic        add_ovf, sub_ovf, addi_ovf;
    logic        unused_bits;

    assign op       = instr[31:26];
    assign rs       = instr[25:21];
    assign rt       = instr[20:16];
    assign rd       = instr[15:11];
    assign funct    = instr[5:0];
    assign sext_imm = {{16{instr[15]}}, instr[15:0]};

    assign pc_plus4      = pc + 32'd4;
    assign branch_target = pc_plus4 + {sext_imm[29:0], 2'b00};
    assign jump_target   = {pc_plus4[31:28], instr[25:0], 2'b00};

    assign rs_val  = (rs == 5'd0) ? 32'd0 : regs[rs];
    assign rt_val  = (rt == 5'd0) ? 32'd0 : regs[rt];
    assign sum     = rs_val + rt_val;
    assign diff    = rs_val - rt_val;
    assign imm_sum = rs_val + sext_imm;

    // Signed overflow: result sign disagrees with the (effective) common operand sign.
    assign add_ovf  = (rs_val[31] == rt_val[31])   && (sum[31]     != rs_val[31]);
    assign sub_ovf  = (rs_val[31] != rt_val[31])   && (diff[31]    != rs_val[31]);
    assign addi_ovf = (rs_val[31] == sext_imm[31]) && (imm_sum[31] != rs_val[31]);

    assign unused_bits = ^{instr[10:6], imm_sum[1:0]};

    cpu_mem #(.WORDS(IM_WORDS)) b2v_im (
        .clk   (clk),
        .we    (1'b0),
        .addr  (pc[31:2]),
        .wdata (32'd0),
        .rdata (instr)
    );

    // Reset blocks stores so nothing is written while rst is held low.
    cpu_mem #(.WORDS(DM_WORDS)) b2v_DM (
        .clk   (clk),
        .we    (mem_write & rst),
        .addr  (imm_sum[31:2]),
        .wdata (rt_val),
        .rdata (mem_rdata)
    );

    always_comb begin
        next_pc   = pc_plus4;
        reg_write = 1'b0;
        wr_addr   = rd;
        wr_data   = sum;
        mem_write = 1'b0;
        ovf       = 1'b0;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD: begin reg_write = 1'b1; wr_data = sum;  ovf = add_ovf; end
                    FN_SUB: begin reg_write = 1'b1; wr_data = diff; ovf = sub_ovf; end
                    FN_AND: begin reg_write = 1'b1; wr_data = rs_val & rt_val; end
                    FN_OR:  begin reg_write = 1'b1; wr_data = rs_val | rt_val; end
                    FN_SLT: begin
                        reg_write = 1'b1;
                        wr_data   = {31'd0, ($signed(rs_val) < $signed(rt_val))};
                    end
                    default: ;
                endcase
            end
            OP_ADDI: begin
                reg_write = 1'b1;
                wr_addr   = rt;
                wr_data   = imm_sum;
                ovf       = addi_ovf;
            end
            OP_LW: begin
                reg_write = 1'b1;
                wr_addr   = rt;
                wr_data   = mem_rdata;
            end
            OP_SW:   mem_write = 1'b1;
            OP_BEQ:  if (rs_val == rt_val) next_pc = branch_target;
            OP_BNE:  if (rs_val != rt_val) next_pc = branch_target;
            OP_J:    next_pc = jump_target;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc <= 32'd0;
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'd0;
            end
        end else begin
            pc <= next_pc;
            if (reg_write && (wr_addr != 5'd0)) begin
                regs[wr_addr] <= wr_data;
            end
        end
    end

    assign PC       = pc;
    assign OPCODE   = op;
    assign Overflow = ovf;
endmodule

// File: tb/tb_cpu_single_cycle.sv
// Testbench for cpu_single_cycle: ALU vector table, directed program sequences and
// random programs compared cycle by cycle against an instruction-level reference model.
`timescale 1ns/1ps

module tb_cpu_single_cycle;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         Overflow;
    logic [31:26] OPCODE;
    logic [31:0]  PC;

    int tests = 0;
    int fails = 0;

    cpu_single_cycle dut (
        .clk      (clk),
        .rst      (rst),
        .Overflow (Overflow),
        .OPCODE   (OPCODE),
        .PC       (PC)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          kind;   // 0 add, 1 sub, 2 and, 3 or, 4 slt, 5 addi (imm = b[15:0])
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ovf;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] prog[$];
    logic [31:0] m_regs[32];
    logic [31:0] m_pc;
    logic [31:0] m_dm[int unsigned];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] r_ins(input int rs, input int rt, input int rd, input int funct);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(funct)};
    endfunction

    function automatic logic [31:0] i_ins(input int op, input int rs, input int rt, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] j_ins(input int target);
        return {6'h02, 26'(target)};
    endfunction

    function automatic int funct_of(input int kind);
        case (kind)
            0: return 'h20;
            1: return 'h22;
            2: return 'h24;
            3: return 'h25;
            default: return 'h2A;
        endcase
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Hold the core in reset before touching memories so no store can land meanwhile.
    task automatic begin_test();
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic load_im();
        for (int i = 0; i < 256; i++) begin
            dut.b2v_im.memory[i] = (i < prog.size()) ? prog[i] : 32'd0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        m_pc = 32'd0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    endtask

    function automatic void m_write(input int r, input logic [31:0] v);
        if (r != 0) m_regs[r] = v;
    endfunction

    // Instruction-level model: executes one instruction from prog[] at m_pc.
    task automatic model_step(output logic exp_ovf, output logic [5:0] exp_op);
        logic [31:0] ins, a, b, imm, npc;
        longint      s, lim_hi, lim_lo;
        int unsigned wi, k;
        int          rs_i, rt_i, rd_i;
        lim_hi  = 64'sd2147483647;
        lim_lo  = -lim_hi - 1;
        wi      = m_pc >> 2;
        ins     = (wi < 256 && int'(wi) < prog.size()) ? prog[wi] : 32'd0;
        exp_op  = ins[31:26];
        exp_ovf = 1'b0;
        rs_i    = int'(ins[25:21]);
        rt_i    = int'(ins[20:16]);
        rd_i    = int'(ins[15:11]);
        a       = m_regs[rs_i];
        b       = m_regs[rt_i];
        imm     = {{16{ins[15]}}, ins[15:0]};
        npc     = m_pc + 32'd4;
        case (ins[31:26])
            6'h00: begin
                case (ins[5:0])
                    6'h20: begin
                        s = longint'($signed(a)) + longint'($signed(b));
                        exp_ovf = (s > lim_hi) || (s < lim_lo);
                        m_write(rd_i, s[31:0]);
                    end
                    6'h22: begin
                        s = longint'($signed(a)) - longint'($signed(b));
                        exp_ovf = (s > lim_hi) || (s < lim_lo);
                        m_write(rd_i, s[31:0]);
                    end
                    6'h24: m_write(rd_i, a & b);
                    6'h25: m_write(rd_i, a | b);
                    6'h2A: m_write(rd_i, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
                    default: ;
                endcase
            end
            6'h08: begin
                s = longint'($signed(a)) + longint'($signed(imm));
                exp_ovf = (s > lim_hi) || (s < lim_lo);
                m_write(rt_i, s[31:0]);
            end
            6'h23: begin
                k = (a + imm) >> 2;
                m_write(rt_i, m_dm.exists(k) ? m_dm[k] : 32'd0);
            end
            6'h2B: begin
                k = (a + imm) >> 2;
                m_dm[k] = b;
            end
            6'h04: if (a == b) npc = m_pc + 32'd4 + (imm << 2);
            6'h05: if (a != b) npc = m_pc + 32'd4 + (imm << 2);
            6'h02: npc = ((m_pc + 32'd4) & 32'hF000_0000) | {4'd0, ins[25:0], 2'b00};
            default: ;
        endcase
        m_pc = npc;
    endtask

    task automatic run_lockstep(input string tag, input int n);
        logic       eo;
        logic [5:0] eop;
        for (int c = 0; c < n; c++) begin
            check($sformatf("%s_pc_c%0d", tag, c), PC, m_pc);
            model_step(eo, eop);
            check($sformatf("%s_op_c%0d", tag, c), 32'(OPCODE), 32'(eop));
            check($sformatf("%s_ovf_c%0d", tag, c), 32'(Overflow), 32'(eo));
            step(1);
        end
    endtask

    task automatic run_branch(input string tag, input int t5_val, input logic [31:0] br, input logic [31:0] exp_next);
        begin_test();
        prog = {};
        prog.push_back(i_ins('h08, 0, 8, 5));
        prog.push_back(i_ins('h08, 0, 13, t5_val));
        while (prog.size() < 26) prog.push_back(32'd0);
        prog[7]  = br;
        prog[22] = j_ins(9);
        prog[25] = j_ins(9);
        load_im();
        do_reset();
        step(7);
        check({tag, "_at28"}, PC, 32'd28);
        step(1);
        check({tag, "_next"}, PC, exp_next);
        if (exp_next == 32'd32) begin
            step(14);
            check({tag, "_at88"}, PC, 32'd88);
        end
        step(1);
        check({tag, "_jump"}, PC, 32'd36);
    endtask

    initial begin
        vec_t        v;
        logic [31:0] sorted_in[12];
        logic [31:0] r;
        logic        ovf_seen, halted;

        vecs.push_back('{"add_small",  0, 32'd5,        32'd7,        32'd12,       1'b0});
        vecs.push_back('{"add_posovf", 0, 32'h7FFFFFFF, 32'd1,        32'h80000000, 1'b1});
        vecs.push_back('{"add_negovf", 0, 32'h80000000, 32'h80000000, 32'd0,        1'b1});
        vecs.push_back('{"add_wrap",   0, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0});
        vecs.push_back('{"sub_small",  1, 32'd10,       32'd3,        32'd7,        1'b0});
        vecs.push_back('{"sub_negovf", 1, 32'h80000000, 32'd1,        32'h7FFFFFFF, 1'b1});
        vecs.push_back('{"sub_posovf", 1, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1'b1});
        vecs.push_back('{"and_mix",    2, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0});
        vecs.push_back('{"and_msb",    2, 32'h80000000, 32'h80000000, 32'h80000000, 1'b0});
        vecs.push_back('{"or_mix",     3, 32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 1'b0});
        vecs.push_back('{"slt_m1_1",   4, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0});
        vecs.push_back('{"slt_1_m1",   4, 32'd1,        32'hFFFFFFFF, 32'd0,        1'b0});
        vecs.push_back('{"slt_eq",     4, 32'd5,        32'd5,        32'd0,        1'b0});
        vecs.push_back('{"addi_ovf",   5, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1});
        vecs.push_back('{"addi_neg",   5, 32'd3,        32'h0000FFFE, 32'd1,        1'b0});
        vecs.push_back('{"addi_novf",  5, 32'h80000000, 32'h0000FFFF, 32'h7FFFFFFF, 1'b1});
        vecs.push_back('{"addi_min",   5, 32'hFFFFFFFF, 32'h00008000, 32'hFFFF7FFF, 1'b0});

        // Vector table: lw both operands, apply the operation, inspect at PC=8 and after.
        foreach (vecs[i]) begin
            v = vecs[i];
            begin_test();
            dut.b2v_DM.memory[0] = v.a;
            dut.b2v_DM.memory[1] = v.b;
            prog = {};
            prog.push_back(i_ins('h23, 0, 8, 0));
            prog.push_back(i_ins('h23, 0, 9, 4));
            if (v.kind == 5) prog.push_back(i_ins('h08, 8, 10, int'(v.b[15:0])));
            else             prog.push_back(r_ins(8, 9, 10, funct_of(v.kind)));
            load_im();
            do_reset();
            check({v.name, "_ovf_lw"}, 32'(Overflow), 32'd0);
            step(2);
            check({v.name, "_pc"}, PC, 32'd8);
            check({v.name, "_op"}, 32'(OPCODE), (v.kind == 5) ? 32'd8 : 32'd0);
            check({v.name, "_ovf"}, 32'(Overflow), 32'(v.ovf));
            step(1);
            check({v.name, "_res"}, dut.regs[10], v.res);
        end

        // Bubble sort of 12 words at byte 512; halts on a self-jump at PC 64.
        begin_test();
        sorted_in = '{32'd55, 32'd88, 32'd0, 32'd22, 32'd77, 32'd11, 32'd99, 32'd33, 32'd110, 32'd66, 32'd121, 32'd44};
        for (int i = 0; i < 12; i++) dut.b2v_DM.memory[128 + i] = sorted_in[i];
        prog = {};
        prog.push_back(i_ins('h08, 0, 16, 512));
        prog.push_back(i_ins('h08, 0, 17, 11));
        prog.push_back(i_ins('h08, 0, 8, 0));
        prog.push_back(i_ins('h08, 16, 10, 0));
        prog.push_back(i_ins('h08, 0, 11, 0));
        prog.push_back(i_ins('h23, 10, 12, 0));
        prog.push_back(i_ins('h23, 10, 13, 4));
        prog.push_back(r_ins(13, 12, 14, 'h2A));
        prog.push_back(i_ins('h04, 14, 0, 2));
        prog.push_back(i_ins('h2B, 10, 13, 0));
        prog.push_back(i_ins('h2B, 10, 12, 4));
        prog.push_back(i_ins('h08, 10, 10, 4));
        prog.push_back(i_ins('h08, 11, 11, 1));
        prog.push_back(i_ins('h05, 11, 17, -9));
        prog.push_back(i_ins('h08, 8, 8, 1));
        prog.push_back(i_ins('h05, 8, 17, -13));
        prog.push_back(j_ins(16));
        load_im();
        do_reset();
        ovf_seen = 1'b0;
        halted   = 1'b0;
        for (int c = 0; c < 5000 && !halted; c++) begin
            if (Overflow) ovf_seen = 1'b1;
            if (PC == 32'd64) halted = 1'b1;
            else step(1);
        end
        check("sort_halted", 32'(halted), 32'd1);
        check("sort_no_ovf", 32'(ovf_seen), 32'd0);
        for (int i = 0; i < 12; i++) begin
            check($sformatf("sort_word%0d", i), dut.b2v_DM.memory[128 + i], 32'(11 * i));
        end

        // Reset sequence on an addi stream, then a mid-stream reset.
        begin_test();
        prog = {};
        prog.push_back(i_ins('h08, 0, 16, 512));
        prog.push_back(i_ins('h08, 0, 17, 12));
        for (int i = 0; i < 14; i++) prog.push_back(i_ins('h08, 18, 18, 1));
        load_im();
        do_reset();
        check("rst_pc0", PC, 32'd0);
        check("rst_s0_zero", dut.regs[16], 32'd0);
        check("rst_r8_zero", dut.regs[8], 32'd0);
        for (int c = 0; c < 5; c++) begin
            check($sformatf("rst_stream_pc%0d", c), PC, 32'(4 * c));
            check($sformatf("rst_stream_ovf%0d", c), 32'(Overflow), 32'd0);
            step(1);
        end
        check("addi_s0", dut.regs[16], 32'd512);
        check("addi_s1", dut.regs[17], 32'd12);
        check("addi_r18", dut.regs[18], 32'd3);
        rst = 1'b0;
        step(1);
        check("midrst_pc", PC, 32'd0);
        check("midrst_s0", dut.regs[16], 32'd0);
        rst = 1'b1;
        step(1);
        check("midrst_release_pc", PC, 32'd4);

        // Reset dominates a store sitting at PC 0.
        begin_test();
        dut.b2v_DM.memory[200] = 32'hDEADBEEF;
        prog = {};
        prog.push_back(i_ins('h2B, 0, 16, 800));
        load_im();
        step(3);
        check("rstdom_dm", dut.b2v_DM.memory[200], 32'hDEADBEEF);
        check("rstdom_pc", PC, 32'd0);
        rst = 1'b1;
        step(1);
        check("rstdom_store", dut.b2v_DM.memory[200], 32'd0);
        check("rstdom_pc4", PC, 32'd4);

        // lw 2**31-1 then addi 1 at PC 104.
        begin_test();
        dut.b2v_DM.memory[140] = 32'h7FFFFFFF;
        prog = {};
        while (prog.size() < 25) prog.push_back(32'd0);
        prog.push_back(i_ins('h23, 0, 8, 560));
        prog.push_back(i_ins('h08, 8, 8, 1));
        load_im();
        do_reset();
        step(25);
        check("ovf_pc100", PC, 32'd100);
        check("ovf_lw_zero", 32'(Overflow), 32'd0);
        step(1);
        check("ovf_pc104", PC, 32'd104);
        check("ovf_flag", 32'(Overflow), 32'd1);
        check("ovf_opcode", 32'(OPCODE), 32'd8);
        step(1);
        check("ovf_result", dut.regs[8], 32'h80000000);
        check("ovf_clear", 32'(Overflow), 32'd0);

        // Branches at PC 28 and jumps back to 36.
        run_branch("bne_taken", 6, i_ins('h05, 8, 13, 17), 32'd100);
        run_branch("bne_fall",  5, i_ins('h05, 8, 13, 17), 32'd32);
        run_branch("beq_taken", 5, i_ins('h04, 8, 13, 17), 32'd100);
        run_branch("beq_fall",  6, i_ins('h04, 8, 13, 17), 32'd32);

        // Fetch beyond the instruction memory executes as nop.
        begin_test();
        prog = {};
        prog.push_back(j_ins(300));
        load_im();
        do_reset();
        step(1);
        check("oor_pc", PC, 32'd1200);
        check("oor_op", 32'(OPCODE), 32'd0);
        check("oor_ovf", 32'(Overflow), 32'd0);
        step(1);
        check("oor_next", PC, 32'd1204);

        // Random programs against the reference model.
        for (int p = 0; p < 4; p++) begin
            begin_test();
            m_dm.delete();
            for (int k = 0; k < 16; k++) begin
                r = $urandom;
                dut.b2v_DM.memory[k] = r;
                m_dm[k] = r;
            end
            prog = {};
            for (int q = 1; q < 8; q++) prog.push_back(i_ins('h08, 0, q, int'($urandom_range(0, 65535))));
            repeat (40) begin
                int sel, rs_r, rt_r, rd_r;
                sel  = int'($urandom_range(0, 9));
                rs_r = int'($urandom_range(0, 7));
                rt_r = int'($urandom_range(0, 7));
                rd_r = int'($urandom_range(0, 7));
                case (sel)
                    0, 1, 2, 3, 4: prog.push_back(r_ins(rs_r, rt_r, rd_r, funct_of(sel)));
                    5: prog.push_back(i_ins('h08, rs_r, rt_r, int'($urandom_range(0, 65535))));
                    6: prog.push_back(i_ins('h23, 0, rt_r, int'($urandom_range(0, 63))));
                    7: prog.push_back(i_ins('h2B, 0, rt_r, int'($urandom_range(0, 63))));
                    8: prog.push_back(i_ins('h04, rs_r, rt_r, int'($urandom_range(0, 3))));
                    default: prog.push_back(i_ins('h05, rs_r, rt_r, int'($urandom_range(0, 3))));
                endcase
            end
            prog.push_back(j_ins(prog.size()));
            load_im();
            do_reset();
            run_lockstep($sformatf("rnd%0d", p), 60);
            for (int q = 1; q < 8; q++) check($sformatf("rnd%0d_reg%0d", p, q), dut.regs[q], m_regs[q]);
            for (int k = 0; k < 16; k++) check($sformatf("rnd%0d_dm%0d", p, k), dut.b2v_DM.memory[k], m_dm[k]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
